banked_work_ram: RTL and testbench
==================================

// Module: banked_work_ram
// PURPOSE
//  Working RAM built from BANKS byte-wide synchronous banks, interleaved on the low address bits.
//  The CPU port is slot-gated by ce2Hd and has priority on every cycle it uses.
//  A second read channel (video/bitmap scan) fetches one full row: one word from every bank at the same row.
//  A zero-fill engine clears the whole array after reset, so no init file is needed.
// PARAMETERS
//  BANKS          2   bank count; power of 2, >=2; BS = log2(BANKS)
//  BANK_AW        11  address width of each bank; one bank holds 2^BANK_AW words
//  DW             8   data width of one bank word
//  CLEAR_ON_RESET 1   1: run the zero-fill after reset; 0: start in IDLE and leave contents undefined
// PORTS
//  clk            in   1             system clock
//  reset_n        in   1             asynchronous, active-low reset
//  ce2Hd          in   1             CPU access slot strobe
//  BA             in   BS+BANK_AW    CPU address; BA[BS-1:0] = bank, upper bits = row
//  SRAMn          in   1             CPU chip select, active low
//  BRWn           in   1             1 = read, 0 = write
//  data_to_sram   in   DW            CPU write data
//  data_from_sram out  DW            CPU read data
//  vid_req        in   1             row fetch request; held high until vid_ack
//  vid_row        in   BANK_AW       row to fetch
//  vid_ack        out  1             1-cycle pulse: request accepted
//  vid_valid      out  1             1-cycle pulse: vid_data valid
//  vid_data       out  DW*BANKS      row data; bank k at [k*DW +: DW]
//  clr_busy       out  1             zero-fill in progress
// BEHAVIOUR
//  - CPU cycle (cpu_acc) = ce2Hd & ~SRAMn. Write: cpu_acc & ~BRWn writes data_to_sram into bank BA[BS-1:0], row BA[top].
//  - CPU read: the bank array reads every cpu_acc cycle. data_from_sram is valid the cycle after cpu_acc.
//  - data_from_sram is muxed by the bank index registered on cpu_acc, and holds until the next cpu_acc read.
//  - Reset (async, reset_n=0):
//      data_from_sram=0, vid_ack=0, vid_valid=0, vid_data=0.
//      clr_busy = CLEAR_ON_RESET; clear row counter = 0.
//      FSM enters CLEAR if CLEAR_ON_RESET, else IDLE.
//      Array contents are not touched by reset itself.
//  - FSM states:
//      CLEAR: each cycle without cpu_acc, write 0 to row cnt in all banks, then cnt++.
//             On a cpu_acc cycle the CPU access wins and cnt holds.
//             After writing row 2^BANK_AW-1: clr_busy<=0, go to IDLE.
//             Clear occupies at least 2^BANK_AW cycles.
//      IDLE:  if vid_req & ~cpu_acc: read row vid_row in all banks, vid_ack=1 this cycle, go to VRD.
//             If cpu_acc in the same cycle, the request waits; no ack.
//      VRD:   vid_valid=1, vid_data=bank outputs. Return to IDLE.
//             vid_data holds until the next VRD.
//             Back-to-back fetches allowed: at most one ack every 2 cycles.
//  - vid_req is ignored in CLEAR. No ack is issued before clr_busy falls.
//  - Priority per cycle: CPU > clear > video. CPU and video never address the array in the same cycle.
//  - CPU write during CLEAR to a row not yet cleared is later overwritten by 0.
//    This is the defined behaviour; software waits for clr_busy=0.
//  - Reset mid-clear or mid-fetch aborts the operation. Clear restarts from row 0 with no vid_valid pulse.
//  - Counter width is BANK_AW+1 so that the terminal row is detected without wrap-around ambiguity.
//  - cpu_acc with BRWn=1 during CLEAR reads the current contents (cleared or stale).
// TESTING
//  T1 reset, CLEAR_ON_RESET=1, no CPU traffic -> clr_busy falls exactly 2048 cycles after reset_n rises;
//     fetch of rows 0, 0x7FF -> vid_data=0.
//  T2 CPU write BA=0x0003 data 0xA5, then read BA=0x0003 and BA=0x0002
//     -> 0xA5 one cycle after the read slot; 0x00 for 0x0002.
//  T3 write 0x11 @0x0010 and 0x22 @0x0011, vid_req with vid_row=8
//     -> vid_ack, then vid_valid the next cycle with vid_data=16'h2211.
//  T4 vid_req held while ce2Hd&~SRAMn on alternate cycles -> ack only on non-CPU cycles;
//     CPU read data intact; one vid_valid per ack.
//  T5 CPU writes 0x5A to row 0x700 during CLEAR at cnt=0x100 -> reads 0x00 after clr_busy=0;
//     clear takes 2048 + (number of CPU slots) cycles.
//  T6 reset_n pulsed low at cnt=0x400 -> outputs return to reset values asynchronously;
//     clear restarts and finishes 2048 free cycles after release.

Source files
------------

// File: rtl/banked_work_ram.sv
// Working RAM made of BANKS interleaved byte-wide synchronous banks. It has a slot-gated CPU port,
// a full-row video fetch channel, and a zero-fill engine that clears the array after reset.
module banked_work_ram #(
    parameter int BANKS          = 2,
    parameter int BANK_AW        = 11,
    parameter int DW             = 8,
    parameter int CLEAR_ON_RESET = 1,
    localparam int BS            = $clog2(BANKS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce2Hd,
    input  logic [BS+BANK_AW-1:0] BA,
    input  logic                  SRAMn,
    input  logic                  BRWn,
    input  logic [DW-1:0]         data_to_sram,
    output logic [DW-1:0]         data_from_sram,
    input  logic                  vid_req,
    input  logic [BANK_AW-1:0]    vid_row,
    output logic                  vid_ack,
    output logic                  vid_valid,
    output logic [DW*BANKS-1:0]   vid_data,
    output logic                  clr_busy
);

    // state    | meaning
    // ST_CLEAR | zero-fill one row per free cycle, CPU may steal cycles
    // ST_IDLE  | array free; accept a video row fetch on a non-CPU cycle
    // ST_VRD   | video row data present on bank outputs, vid_valid high
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_VRD   = 2'd2
    } state_t;

    localparam logic [BANK_AW:0] CLR_LAST = {1'b0, {BANK_AW{1'b1}}};

    state_t               state, state_nxt;
    logic [BANK_AW:0]     clr_cnt, clr_cnt_nxt;
    logic                 clr_busy_nxt;
    logic                 clr_we;
    logic                 vid_rd;

    logic                 cpu_acc;
    logic [BS-1:0]        cpu_bank;
    logic [BANK_AW-1:0]   cpu_row;
    logic                 cpu_rd_q;
    logic [BS-1:0]        cpu_sel_q;
    logic [DW-1:0]        cpu_dout;
    logic [DW-1:0]        dout_hold;
    logic [DW*BANKS-1:0]  vid_hold;

    logic                 bank_en;
    logic [BANK_AW-1:0]   bank_addr;
    logic [DW-1:0]        bank_wdata;
    logic [DW*BANKS-1:0]  bank_q_all;

    assign cpu_acc  = ce2Hd & ~SRAMn;
    assign cpu_bank = BA[BS-1:0];
    assign cpu_row  = BA[BS+BANK_AW-1:BS];

    always_comb begin
        state_nxt    = state;
        clr_cnt_nxt  = clr_cnt;
        clr_busy_nxt = clr_busy;
        clr_we       = 1'b0;
        vid_rd       = 1'b0;
        vid_ack      = 1'b0;
        vid_valid    = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (!cpu_acc) begin
                    clr_we      = 1'b1;
                    clr_cnt_nxt = clr_cnt + 1'b1;
                    if (clr_cnt == CLR_LAST) begin
                        clr_busy_nxt = 1'b0;
                        state_nxt    = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (vid_req && !cpu_acc) begin
                    vid_ack   = 1'b1;
                    vid_rd    = 1'b1;
                    state_nxt = ST_VRD;
                end
            end
            ST_VRD: begin
                vid_valid = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt   <= '0;
            clr_busy  <= (CLEAR_ON_RESET != 0);
            cpu_rd_q  <= 1'b0;
            cpu_sel_q <= '0;
            dout_hold <= '0;
            vid_hold  <= '0;
        end else begin
            state    <= state_nxt;
            clr_cnt  <= clr_cnt_nxt;
            clr_busy <= clr_busy_nxt;
            cpu_rd_q <= cpu_acc & BRWn;
            if (cpu_acc && BRWn) begin
                cpu_sel_q <= cpu_bank;
            end
            if (cpu_rd_q) begin
                dout_hold <= cpu_dout;
            end
            if (state == ST_VRD) begin
                vid_hold <= bank_q_all;
            end
        end
    end

    // One shared row address per cycle: CPU first, then clear, then video.
    assign bank_en    = cpu_acc | clr_we | vid_rd;
    assign bank_addr  = cpu_acc ? cpu_row : (clr_we ? clr_cnt[BANK_AW-1:0] : vid_row);
    assign bank_wdata = cpu_acc ? data_to_sram : '0;

    for (genvar k = 0; k < BANKS; k++) begin : g_bank
        logic [DW-1:0] mem [0:(2**BANK_AW)-1];
        logic [DW-1:0] q;
        logic          we;

        assign we = clr_we | (cpu_acc & ~BRWn & (int'(cpu_bank) == k));

        always_ff @(posedge clk) begin
            if (bank_en) begin
                if (we) begin
                    mem[bank_addr] <= bank_wdata;
                end
                q <= mem[bank_addr];
            end
        end

        assign bank_q_all[k*DW +: DW] = q;
    end

    assign cpu_dout       = bank_q_all[int'(cpu_sel_q)*DW +: DW];
    assign data_from_sram = cpu_rd_q ? cpu_dout : dout_hold;
    assign vid_data       = (state == ST_VRD) ? bank_q_all : vid_hold;

endmodule

// File: tb/tb_banked_work_ram.sv
// Directed bench for banked_work_ram. It covers the post-reset clear, CPU access, row fetch,
// CPU/video arbitration, CPU cycle stealing during the clear, and a reset that lands mid-clear.
module tb_banked_work_ram;

    logic        clk;
    logic        reset_n;
    logic        ce2Hd;
    logic [11:0] BA;
    logic        SRAMn;
    logic        BRWn;
    logic [7:0]  data_to_sram;
    logic [7:0]  data_from_sram;
    logic        vid_req;
    logic [10:0] vid_row;
    logic        vid_ack;
    logic        vid_valid;
    logic [15:0] vid_data;
    logic        clr_busy;

    int n_tests = 0;
    int n_fail  = 0;

    banked_work_ram dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ce2Hd          (ce2Hd),
        .BA             (BA),
        .SRAMn          (SRAMn),
        .BRWn           (BRWn),
        .data_to_sram   (data_to_sram),
        .data_from_sram (data_from_sram),
        .vid_req        (vid_req),
        .vid_row        (vid_row),
        .vid_ack        (vid_ack),
        .vid_valid      (vid_valid),
        .vid_data       (vid_data),
        .clr_busy       (clr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        ce2Hd   = 1'b0;
        SRAMn   = 1'b1;
        BRWn    = 1'b1;
        vid_req = 1'b0;
    endtask

    // Assert reset at a falling edge, check the reset outputs, then release before the next rising edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        #1;
        check({tag, "_rst_dout"}, data_from_sram, 0);
        check({tag, "_rst_vdata"}, vid_data, 0);
        check({tag, "_rst_vvalid"}, vid_valid, 0);
        check({tag, "_rst_busy"}, clr_busy, 1);
        #1;
        reset_n = 1'b1;
    endtask

    // Run the zero-fill while vid_req is held high. Optionally steal one cycle for a CPU access.
    // Returns the number of rising edges until clr_busy fell, or until stop_at was reached.
    task automatic clear_run(input int cpu_at, input logic cpu_we, input logic [11:0] ba,
                             input logic [7:0] d, input int stop_at,
                             output int cycles, output int acks);
        cycles = 0;
        acks   = 0;
        while (cycles < 5000) begin
            vid_req = 1'b1;
            vid_row = 11'd0;
            if (cycles == cpu_at) begin
                ce2Hd = 1'b1; SRAMn = 1'b0; BRWn = ~cpu_we; BA = ba; data_to_sram = d;
            end else begin
                ce2Hd = 1'b0; SRAMn = 1'b1; BRWn = 1'b1;
            end
            #1;
            if (vid_ack) acks++;
            @(posedge clk);
            #1;
            cycles++;
            if (!clr_busy || cycles == stop_at) break;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic cpu_cycle(input logic we, input logic [11:0] ba, input logic [7:0] d);
        @(negedge clk);
        ce2Hd = 1'b1; SRAMn = 1'b0; BRWn = ~we; BA = ba; data_to_sram = d;
        @(negedge clk);
        ce2Hd = 1'b0; SRAMn = 1'b1; BRWn = 1'b1;
        #1;
    endtask

    task automatic vid_fetch(input string tag, input logic [10:0] row, output logic [15:0] data);
        int w;
        @(negedge clk);
        vid_req = 1'b1;
        vid_row = row;
        #1;
        w = 0;
        while (!vid_ack && w < 8) begin
            @(negedge clk);
            #1;
            w++;
        end
        check({tag, "_ack"}, vid_ack, 1);
        @(negedge clk);
        vid_req = 1'b0;
        #1;
        check({tag, "_valid"}, vid_valid, 1);
        data = vid_data;
    endtask

    initial begin
        int          cyc, acks, n_ack, n_valid, ack_cpu;
        logic [15:0] vd;

        reset_n      = 1'b1;
        BA           = '0;
        data_to_sram = '0;
        vid_row      = '0;
        idle_inputs();

        // T1: clear with no CPU traffic, then fetch the first and last rows
        do_reset("t1");
        clear_run(-1, 1'b0, 12'h000, 8'h00, -1, cyc, acks);
        check("t1_clear_cycles", cyc, 2048);
        check("t1_no_ack_in_clear", acks, 0);
        vid_fetch("t1_row0", 11'h000, vd);
        check("t1_row0_data", vd, 16'h0000);
        vid_fetch("t1_row7ff", 11'h7FF, vd);
        check("t1_row7ff_data", vd, 16'h0000);

        // T2: CPU write then reads of the written and neighbouring bank
        cpu_cycle(1'b1, 12'h003, 8'hA5);
        cpu_cycle(1'b0, 12'h003, 8'h00);
        check("t2_read_003", data_from_sram, 8'hA5);
        cpu_cycle(1'b0, 12'h002, 8'h00);
        check("t2_read_002", data_from_sram, 8'h00);

        // T3: two banks of row 8 written through the CPU, fetched as one row
        cpu_cycle(1'b1, 12'h010, 8'h11);
        cpu_cycle(1'b1, 12'h011, 8'h22);
        vid_fetch("t3", 11'd8, vd);
        check("t3_row8_data", vd, 16'h2211);
        @(negedge clk);
        #1;
        check("t3_valid_pulse", vid_valid, 0);
        check("t3_vdata_hold", vid_data, 16'h2211);

        // T4: CPU reads on alternate slots while vid_req stays high; acks land only on free slots
        n_ack = 0; n_valid = 0; ack_cpu = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ce2Hd = (i % 2 == 0); SRAMn = 1'b0; BRWn = 1'b1; BA = 12'h003;
            vid_req = 1'b1; vid_row = 11'd1;
            #1;
            if (vid_ack) begin
                n_ack++;
                if (ce2Hd) ack_cpu++;
            end
            if (vid_valid) n_valid++;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        if (vid_valid) n_valid++;
        check("t4_ack_count", n_ack, 4);
        check("t4_ack_on_cpu", ack_cpu, 0);
        check("t4_valid_count", n_valid, 4);
        check("t4_cpu_data", data_from_sram, 8'hA5);
        check("t4_row1_data", vid_data, 16'hA500);

        // T5: CPU write to row 0x700 at clear row 0x100 is wiped; the clear takes one extra cycle
        do_reset("t5");
        clear_run(256, 1'b1, 12'hE00, 8'h5A, -1, cyc, acks);
        check("t5_clear_cycles", cyc, 2049);
        check("t5_no_ack_in_clear", acks, 0);
        cpu_cycle(1'b0, 12'hE00, 8'h00);
        check("t5_read_e00", data_from_sram, 8'h00);
        cpu_cycle(1'b0, 12'h003, 8'h00);
        check("t5_read_003", data_from_sram, 8'h00);

        // T6: stale read during clear, then reset at clear row 0x400 and a full restart
        cpu_cycle(1'b1, 12'hC01, 8'h77);
        do_reset("t6a");
        clear_run(12'h3F0, 1'b0, 12'hC01, 8'h00, 12'h401, cyc, acks);
        check("t6_stop_cycles", cyc, 12'h401);
        check("t6_stale_read", data_from_sram, 8'h77);
        check("t6_busy_mid", clr_busy, 1);
        reset_n = 1'b0;
        #1;
        check("t6_async_dout", data_from_sram, 8'h00);
        check("t6_async_valid", vid_valid, 0);
        check("t6_async_vdata", vid_data, 16'h0000);
        check("t6_async_busy", clr_busy, 1);
        #1;
        reset_n = 1'b1;
        clear_run(-1, 1'b0, 12'h000, 8'h00, -1, cyc, acks);
        check("t6_clear_cycles", cyc, 2048);
        check("t6_no_ack_in_clear", acks, 0);
        cpu_cycle(1'b0, 12'hC01, 8'h00);
        check("t6_read_c01", data_from_sram, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
